// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with active/shadow weight double buffering.
// The next weight streams down the column while the current one computes.
module pe_ws_dbuf #(
    parameter int L_WIDTH  = 32,
    parameter int S_WIDTH  = 8,
    parameter bit LAST_COL = 1'b0,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic                      PE_clk,
    input  logic                      PE_rst_n,
    input  logic                      PE_mode,
    input  logic                      PE_en_up,
    input  logic [L_WIDTH-1:0]        PE_data_up,
    input  logic                      PE_en_left,
    input  logic [S_WIDTH-1:0]        PE_data_left,
    input  logic                      PE_swap,
    output logic                      PE_en_down,
    output logic [L_WIDTH-1:0]        PE_data_down,
    output logic                      PE_en_right,
    output logic [S_WIDTH-1:0]        PE_data_right,
    output logic                      PE_wt_ready,
    output logic                      PE_shadow_full,
    output logic                      PE_ovf
);

    // State bits are {wt_ready, shadow_full} so flags come straight from the register.
    typedef enum logic [1:0] {
        EMPTY        = 2'b00,
        SHADOW       = 2'b01,
        READY        = 2'b10,
        READY_SHADOW = 2'b11
    } wt_state_e;

    wt_state_e                state_q;
    logic [S_WIDTH-1:0]       active_q;
    logic [S_WIDTH-1:0]       shadow_q;
    logic                     en_down_q;
    logic [L_WIDTH-1:0]       data_down_q;
    logic                     ovf_q;

    logic                     load;
    logic                     comp;
    logic [S_WIDTH-1:0]       act_eff;
    logic signed [2*S_WIDTH-1:0] left_ext;
    logic signed [2*S_WIDTH-1:0] act_ext;
    logic signed [2*S_WIDTH-1:0] prod;
    logic [L_WIDTH:0]         sum;
    logic                     ovf_d;
    logic [L_WIDTH-1:0]       psum_d;

    always_comb begin
        load     = PE_mode & PE_en_up;
        comp     = ~PE_mode & PE_en_left;
        act_eff  = state_q[1] ? active_q : '0;
        left_ext = {{S_WIDTH{PE_data_left[S_WIDTH-1]}}, PE_data_left};
        act_ext  = {{S_WIDTH{act_eff[S_WIDTH-1]}}, act_eff};
        prod     = left_ext * act_ext;
        sum      = {{(L_WIDTH+1-2*S_WIDTH){prod[2*S_WIDTH-1]}}, prod}
                 + {PE_data_up[L_WIDTH-1], PE_data_up};
        // Out of range exactly when the extra sign bit disagrees with the L_WIDTH sign bit.
        ovf_d    = sum[L_WIDTH] ^ sum[L_WIDTH-1];
        psum_d   = sum[L_WIDTH-1:0];
        if (SAT_EN && ovf_d) begin
            psum_d = sum[L_WIDTH] ? {1'b1, {(L_WIDTH-1){1'b0}}}
                                  : {1'b0, {(L_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            state_q     <= EMPTY;
            active_q    <= '0;
            shadow_q    <= '0;
            en_down_q   <= 1'b0;
            data_down_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            en_down_q <= load | comp;
            ovf_q     <= comp & ovf_d;
            if (load) begin
                data_down_q <= PE_data_up;
                shadow_q    <= PE_data_up[S_WIDTH-1:0];
            end else if (comp) begin
                data_down_q <= psum_d;
            end
            if (PE_swap && state_q[0]) begin
                active_q <= shadow_q;
            end
            case (state_q)
                EMPTY:        if (load) state_q <= SHADOW;
                SHADOW:       if (PE_swap) state_q <= load ? READY_SHADOW : READY;
                READY:        if (load) state_q <= READY_SHADOW;
                READY_SHADOW: if (PE_swap && !load) state_q <= READY;
                default:      state_q <= EMPTY;
            endcase
        end
    end

    generate
        if (LAST_COL) begin : g_last
            assign PE_en_right   = 1'b0;
            assign PE_data_right = '0;
        end else begin : g_fwd
            logic               en_right_q;
            logic [S_WIDTH-1:0] data_right_q;
            always_ff @(posedge PE_clk or negedge PE_rst_n) begin
                if (!PE_rst_n) begin
                    en_right_q   <= 1'b0;
                    data_right_q <= '0;
                end else begin
                    en_right_q <= comp;
                    if (comp) data_right_q <= PE_data_left;
                end
            end
            assign PE_en_right   = en_right_q;
            assign PE_data_right = data_right_q;
        end
    endgenerate

    assign PE_en_down     = en_down_q;
    assign PE_data_down   = data_down_q;
    assign PE_wt_ready    = state_q[1];
    assign PE_shadow_full = state_q[0];
    assign PE_ovf         = ovf_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed bench for pe_ws_dbuf: default, SAT_EN=0 and LAST_COL=1 instances share stimulus.
module tb_pe_ws_dbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, en_up, en_left, swap;
    logic [31:0] data_up;
    logic [7:0]  data_left;

    logic        a_en_down, a_en_right, a_rdy, a_full, a_ovf;
    logic [31:0] a_down;
    logic [7:0]  a_right;
    logic        b_en_down, b_en_right, b_rdy, b_full, b_ovf;
    logic [31:0] b_down;
    logic [7:0]  b_right;
    logic        c_en_down, c_en_right, c_rdy, c_full, c_ovf;
    logic [31:0] c_down;
    logic [7:0]  c_right;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pe_ws_dbuf #(.L_WIDTH(32), .S_WIDTH(8), .LAST_COL(1'b0), .SAT_EN(1'b1)) u_a (
        .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode(mode), .PE_en_up(en_up),
        .PE_data_up(data_up), .PE_en_left(en_left), .PE_data_left(data_left),
        .PE_swap(swap), .PE_en_down(a_en_down), .PE_data_down(a_down),
        .PE_en_right(a_en_right), .PE_data_right(a_right), .PE_wt_ready(a_rdy),
        .PE_shadow_full(a_full), .PE_ovf(a_ovf));

    pe_ws_dbuf #(.L_WIDTH(32), .S_WIDTH(8), .LAST_COL(1'b0), .SAT_EN(1'b0)) u_b (
        .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode(mode), .PE_en_up(en_up),
        .PE_data_up(data_up), .PE_en_left(en_left), .PE_data_left(data_left),
        .PE_swap(swap), .PE_en_down(b_en_down), .PE_data_down(b_down),
        .PE_en_right(b_en_right), .PE_data_right(b_right), .PE_wt_ready(b_rdy),
        .PE_shadow_full(b_full), .PE_ovf(b_ovf));

    pe_ws_dbuf #(.L_WIDTH(32), .S_WIDTH(8), .LAST_COL(1'b1), .SAT_EN(1'b1)) u_c (
        .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode(mode), .PE_en_up(en_up),
        .PE_data_up(data_up), .PE_en_left(en_left), .PE_data_left(data_left),
        .PE_swap(swap), .PE_en_down(c_en_down), .PE_data_down(c_down),
        .PE_en_right(c_en_right), .PE_data_right(c_right), .PE_wt_ready(c_rdy),
        .PE_shadow_full(c_full), .PE_ovf(c_ovf));

    task automatic idle_inputs();
        mode = 1'b0; en_up = 1'b0; en_left = 1'b0; swap = 1'b0;
        data_up = '0; data_left = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] w, input logic sw);
        idle_inputs();
        mode = 1'b1; en_up = 1'b1; data_up = w; swap = sw;
        cycle();
        idle_inputs();
    endtask

    task automatic do_swap();
        idle_inputs();
        swap = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic do_comp(input logic [7:0] l, input logic [31:0] u, input logic sw);
        idle_inputs();
        en_left = 1'b1; data_left = l; data_up = u; swap = sw;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({a_en_down, a_down, a_en_right, a_right, a_rdy, a_full, a_ovf} !== 45'd0) begin
            fails++; $display("FAIL reset_a: got %h want 0", {a_en_down, a_down, a_en_right, a_right, a_rdy, a_full, a_ovf});
        end
        tests++;
        if ({c_en_down, c_down, c_en_right, c_right, c_rdy, c_full, c_ovf} !== 45'd0) begin
            fails++; $display("FAIL reset_c: got %h want 0", {c_en_down, c_down, c_en_right, c_right, c_rdy, c_full, c_ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_swap_empty();
        do_swap();
        tests++;
        if ({a_rdy, a_full} !== 2'b00) begin
            fails++; $display("FAIL swap_empty: got rdy/full=%b want 00", {a_rdy, a_full});
        end
        // en_left is ignored in load mode
        idle_inputs();
        mode = 1'b1; en_left = 1'b1; data_left = 8'h11;
        cycle();
        idle_inputs();
        tests++;
        if ({a_en_down, a_en_right, a_full} !== 3'b000) begin
            fails++; $display("FAIL left_in_load: got %b want 000", {a_en_down, a_en_right, a_full});
        end
        do_comp(8'd5, 32'd42, 1'b0);
        tests++;
        if (a_down !== 32'd42 || a_en_down !== 1'b1) begin
            fails++; $display("FAIL passthrough: got %h/%b want 0000002a/1", a_down, a_en_down);
        end
    endtask

    task automatic test_load_swap();
        do_load(32'h0000_0003, 1'b0);
        tests++;
        if ({a_en_down, a_down, a_full, a_rdy} !== {1'b1, 32'd3, 1'b1, 1'b0}) begin
            fails++; $display("FAIL load: got en=%b d=%h full=%b rdy=%b want 1 00000003 1 0", a_en_down, a_down, a_full, a_rdy);
        end
        do_swap();
        tests++;
        if ({a_rdy, a_full, a_en_down} !== 3'b100) begin
            fails++; $display("FAIL swap: got rdy/full/en=%b want 100", {a_rdy, a_full, a_en_down});
        end
    endtask

    task automatic test_compute();
        do_comp(8'hFB, 32'd100, 1'b0);
        tests++;
        if ({a_en_down, a_down, a_en_right, a_right, a_ovf} !== {1'b1, 32'd85, 1'b1, 8'hFB, 1'b0}) begin
            fails++; $display("FAIL compute_a: got %b %h %b %h %b want 1 00000055 1 fb 0", a_en_down, a_down, a_en_right, a_right, a_ovf);
        end
        tests++;
        if ({b_down, c_down, c_en_right, c_right} !== {32'd85, 32'd85, 1'b0, 8'h00}) begin
            fails++; $display("FAIL compute_bc: got b=%h c=%h c_en_r=%b c_r=%h want 55 55 0 00", b_down, c_down, c_en_right, c_right);
        end
        cycle();
        tests++;
        if ({a_en_down, a_down, a_en_right, a_right} !== {1'b0, 32'd85, 1'b0, 8'hFB}) begin
            fails++; $display("FAIL hold: got %b %h %b %h want 0 00000055 0 fb", a_en_down, a_down, a_en_right, a_right);
        end
    endtask

    task automatic test_swap_load_same();
        do_load(32'd7, 1'b0);
        do_load(32'd9, 1'b1);
        tests++;
        if ({a_rdy, a_full, a_down} !== {1'b1, 1'b1, 32'd9}) begin
            fails++; $display("FAIL swap_load: got rdy=%b full=%b d=%h want 1 1 00000009", a_rdy, a_full, a_down);
        end
        // en_up is ignored in compute mode; swap alongside compute affects only the next op
        idle_inputs();
        en_left = 1'b1; en_up = 1'b1; data_left = 8'd2; data_up = 32'd0; swap = 1'b1;
        cycle();
        idle_inputs();
        tests++;
        if ({a_down, a_full} !== {32'd14, 1'b0}) begin
            fails++; $display("FAIL active7: got d=%h full=%b want 0000000e 0", a_down, a_full);
        end
        do_comp(8'd2, 32'd0, 1'b0);
        tests++;
        if (a_down !== 32'd18) begin
            fails++; $display("FAIL active9: got %h want 00000012", a_down);
        end
    endtask

    task automatic test_saturation();
        do_load(32'hFFFF_FF80, 1'b0);
        do_swap();
        do_comp(8'h80, 32'h7FFF_F000, 1'b0);
        tests++;
        if ({a_down, a_ovf, c_down} !== {32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF}) begin
            fails++; $display("FAIL sat_pos: got %h ovf=%b c=%h want 7fffffff 1 7fffffff", a_down, a_ovf, c_down);
        end
        tests++;
        if ({b_down, b_ovf} !== {32'h8000_3000, 1'b1}) begin
            fails++; $display("FAIL wrap_pos: got %h ovf=%b want 80003000 1", b_down, b_ovf);
        end
        do_comp(8'h80, 32'h7FFF_BFFF, 1'b0);
        tests++;
        if ({a_down, a_ovf, b_down, b_ovf} !== {32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0}) begin
            fails++; $display("FAIL exact_max: got %h %b %h %b want 7fffffff 0 7fffffff 0", a_down, a_ovf, b_down, b_ovf);
        end
        do_comp(8'h7F, 32'h8000_0000, 1'b0);
        tests++;
        if ({a_down, a_ovf, b_down, b_ovf} !== {32'h8000_0000, 1'b1, 32'h7FFF_C080, 1'b1}) begin
            fails++; $display("FAIL sat_neg: got %h %b %h %b want 80000000 1 7fffc080 1", a_down, a_ovf, b_down, b_ovf);
        end
        cycle();
        tests++;
        if ({a_ovf, b_ovf, c_en_right, c_right} !== 11'd0) begin
            fails++; $display("FAIL ovf_pulse: got %b want 0", {a_ovf, b_ovf, c_en_right, c_right});
        end
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        en_left = 1'b1; data_left = 8'd3; data_up = 32'd1000;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a_en_down, a_down, a_en_right, a_right, a_rdy, a_full, a_ovf} !== 45'd0) begin
            fails++; $display("FAIL reset_midop: got %h want 0", {a_en_down, a_down, a_en_right, a_right, a_rdy, a_full, a_ovf});
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        do_comp(8'd4, 32'd10, 1'b0);
        tests++;
        if ({a_down, a_rdy} !== {32'd10, 1'b0}) begin
            fails++; $display("FAIL after_reset: got %h rdy=%b want 0000000a 0", a_down, a_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_swap_empty();
        test_load_swap();
        test_compute();
        test_swap_load_same();
        test_saturation();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
